// File: rtl/bus_arbiter8_pkg.sv
// Shared constants and types for the eight-way round-robin bus arbiter.
package bus_arbiter8_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter8_rr_pick8.sv
// Rotated priority encoder: lowest set request at or above ptr, else lowest overall.
module rr_pick8
    import bus_arbiter8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_hi;

    assign w_mask = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
    assign w_hi   = req & w_mask;
    assign any    = |req;

    // Second pass over the masked vector overrides the plain pick whenever it finds a bit.
    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_hi[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter granting bursts of up to MAX_BURST words and registering the selected word onto a shared bus.
module bus_arbiter8
    import bus_arbiter8_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_c,
    input  logic [WIDTH-1:0]   in_d,
    input  logic [WIDTH-1:0]   in_e,
    input  logic [WIDTH-1:0]   in_f,
    input  logic [WIDTH-1:0]   in_g,
    input  logic [WIDTH-1:0]   in_h,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   sel,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic               busy
);

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]   r_sel, w_sel_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_out, w_out_nxt;
    logic               r_vld, w_vld_nxt;

    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [WIDTH-1:0]   w_mux;
    logic [CNT_W-1:0]   w_cnt_inc;

    rr_pick8 u_pick (
        .req (req),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    always_comb begin
        w_mux = '0;
        case (r_sel)
            3'd0: w_mux = in_a;
            3'd1: w_mux = in_b;
            3'd2: w_mux = in_c;
            3'd3: w_mux = in_d;
            3'd4: w_mux = in_e;
            3'd5: w_mux = in_f;
            3'd6: w_mux = in_g;
            3'd7: w_mux = in_h;
        endcase
    end

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_vld_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_gnt_nxt = '0;
                if (w_pick_any) begin
                    w_sel_nxt   = w_pick_idx;
                    w_gnt_nxt   = onehot8(w_pick_idx);
                    w_cnt_nxt   = '0;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (req[r_sel]) begin
                    w_out_nxt = w_mux;
                    w_vld_nxt = 1'b1;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CNT_W'(MAX_BURST)) begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_ptr_nxt   = r_sel + IDX_W'(1);
                    end
                end else begin
                    // Early release: no transfer, bus word stays put.
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = r_sel + IDX_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_vld   <= w_vld_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out       = r_out;
    assign out_valid = r_vld;
    assign busy      = (r_state == GRANT);

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8: reset, bursts, rotation, wrap, early release, mid-burst reset.
module tb_bus_arbiter8;

    logic        clock;
    logic        reset_n;
    logic [7:0]  req;
    logic [15:0] d [8];
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic [15:0] out;
    logic        out_valid;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    bus_arbiter8 #(.WIDTH(16), .MAX_BURST(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .in_a      (d[0]),
        .in_b      (d[1]),
        .in_c      (d[2]),
        .in_d      (d[3]),
        .in_e      (d[4]),
        .in_f      (d[5]),
        .in_g      (d[6]),
        .in_h      (d[7]),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 32'h00);
        chk({tag, ".sel"}, 32'(sel), 32'h0);
        chk({tag, ".out"}, 32'(out), 32'h0000);
        chk({tag, ".vld"}, 32'(out_valid), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b1;
        req     = 8'h00;
        for (int i = 0; i < 8; i++) d[i] = 16'h0;

        // 1: asynchronous reset before any clock edge
        #1 reset_n = 1'b0;
        #1 chk_zero("rst");
        #1 reset_n = 1'b1;
        @(negedge clock);
        step();
        chk("idle.gnt", 32'(gnt), 32'h00);
        chk("idle.busy", 32'(busy), 32'h0);

        // 2: single requester 3, continuous
        req  = 8'h08;
        d[3] = 16'h1234;
        step();
        chk("t2.gnt", 32'(gnt), 32'h08);
        chk("t2.sel", 32'(sel), 32'h3);
        chk("t2.busy", 32'(busy), 32'h1);
        chk("t2.vld0", 32'(out_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2.out", 32'(out), 32'h1234);
            chk("t2.vld", 32'(out_valid), 32'h1);
            chk("t2.gntb", 32'(gnt), (k == 3) ? 32'h00 : 32'h08);
        end
        chk("t2.busy_end", 32'(busy), 32'h0);
        step();
        chk("t2.regnt", 32'(gnt), 32'h08);
        chk("t2.idle_vld", 32'(out_valid), 32'h0);
        chk("t2.hold", 32'(out), 32'h1234);

        // 3: all requesting, rotation 0..7,0
        req = 8'h00;
        do_reset();
        for (int i = 0; i < 8; i++) d[i] = 16'hA000 + 16'(i * 16'h0111);
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("t3.gnt", 32'(gnt), 32'(8'h01 << (i % 8)));
            chk("t3.sel", 32'(sel), 32'(i % 8));
            for (int k = 0; k < 4; k++) begin
                step();
                chk("t3.out", 32'(out), 32'(16'hA000 + 16'((i % 8) * 16'h0111)));
                chk("t3.vld", 32'(out_valid), 32'h1);
            end
        end

        // 4: grant to 5 leaves ptr=6; req 0x21 then grants 0 before 5
        req = 8'h00;
        do_reset();
        d[0] = 16'h0A0A;
        d[5] = 16'h5F5F;
        req  = 8'h20;
        step();
        chk("t4.gnt5", 32'(gnt), 32'h20);
        req = 8'h21;
        repeat (4) step();
        chk("t4.out5", 32'(out), 32'h5F5F);
        step();
        chk("t4.gnt0", 32'(gnt), 32'h01);
        repeat (4) step();
        chk("t4.out0", 32'(out), 32'h0A0A);
        step();
        chk("t4.gnt5b", 32'(gnt), 32'h20);

        // 5: early release of requester 2 after two words
        req = 8'h00;
        do_reset();
        req  = 8'h04;
        d[2] = 16'h2201;
        step();
        chk("t5.gnt", 32'(gnt), 32'h04);
        step();
        chk("t5.w1", 32'(out), 32'h2201);
        d[2] = 16'h2202;
        step();
        chk("t5.w2", 32'(out), 32'h2202);
        req  = 8'h0B;
        d[2] = 16'h2203;
        step();
        chk("t5.rel_vld", 32'(out_valid), 32'h0);
        chk("t5.rel_out", 32'(out), 32'h2202);
        chk("t5.rel_gnt", 32'(gnt), 32'h00);
        chk("t5.rel_busy", 32'(busy), 32'h0);
        step();
        chk("t5.next", 32'(gnt), 32'h08);

        // 6: reset in the middle of requester 4's burst
        req = 8'h00;
        do_reset();
        req  = 8'h10;
        d[4] = 16'h4444;
        step();
        chk("t6.gnt", 32'(gnt), 32'h10);
        step();
        step();
        chk("t6.w2", 32'(out), 32'h4444);
        #2 reset_n = 1'b0;
        #1 chk_zero("t6.rst");
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("t6.regnt", 32'(gnt), 32'h10);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6.out", 32'(out), 32'h4444);
            chk("t6.vld", 32'(out_valid), 32'h1);
        end
        chk("t6.end_gnt", 32'(gnt), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
